ysyx_23060096_ifu: RTL
======================

Name: ysyx_23060096_ifu

Overview:
- Instruction fetch unit; sits directly upstream of the decode/control-generation stage and supplies its 32-bit instruction word.
- Owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions in a small FIFO and presents {pc, inst, err} to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) that flush buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid, one per accepted request, in order
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  access fault for this response
redirect_valid  in  1  redirect fetch stream this cycle
redirect_pc  in  32  new fetch address; bits [1:0] ignored
out_valid  out  1  instruction available to decode
out_ready  in  1  decode consumes instruction
out_inst  out  32  instruction word (head of FIFO)
out_pc  out  32  PC of out_inst
out_err  out  1  fetch fault flag for out_inst

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, FSM=REQ, FIFO empty, drop=0.
- Reset outputs: imem_req_valid=0, out_valid=0. out_inst, out_pc, out_err=0.
- After reset deasserts, imem_req_valid may rise no earlier than the first clock edge.
- Maximum one outstanding request.
- Credit rule: a request is issued only if FIFO count + outstanding < FIFO_DEPTH.
- FSM state REQ:
  - imem_req_valid=credit; imem_req_addr=fetch_pc.
  - On handshake (valid&&ready): fetch_pc<=fetch_pc+4 (wraps mod 2^32), go to WAIT.
  - Once asserted, req_valid and addr stay stable until accepted.
- FSM state WAIT:
  - On imem_rsp_valid: push {pc_of_request, data, err} unless drop=1; clear drop; go to REQ.
  - The next request issues no earlier than the following cycle.
- imem_rsp_valid outside WAIT is a protocol violation; it is ignored and flagged by an assertion.
- Redirect has highest priority. On redirect_valid:
  - fetch_pc<={redirect_pc[31:2],2'b00} and FIFO is flushed (count=0).
  - If a request is outstanding, or is accepted in the same cycle, drop<=1 so its response is discarded.
  - A pending unaccepted request completes at its old address; that response is dropped; the next request uses the new fetch_pc.
- Redirect in the same cycle as an out pop: the flush wins.
- Redirect in the same cycle as a response: the response is discarded.
- Latency:
  - Response at cycle N gives out_valid at N+1 (registered FIFO, no rsp->out combinational path).
  - Redirect at cycle N gives request at new PC at N+1 if no outstanding request; otherwise the cycle after the dropped response.
- FIFO behaviour:
  - out_valid = !empty; pop on out_valid&&out_ready.
  - Push and pop in the same cycle are legal; full cannot overflow because of the credit rule.
- Errors: out_err travels with its entry; fetching continues; decode handles the trap.
- No combinational path from out_ready or redirect_valid to imem_req_valid.

Decomposition:
- Shared package holds:
  - PC/instruction width constant (32)
  - RESET_PC default
  - FSM state encoding {REQ, WAIT}
  - FIFO entry struct {pc[31:0], inst[31:0], err}
- One natural sub-module: ysyx_23060096_ifu_fifo, a synchronous FIFO with flush, count output and registered head.

Test Plan:
- Reset then imem_req_ready=1, memory returns 1-cycle responses -> req addrs 0x80000000, 0x80000004, ...; out_pc/out_inst match in order; out_valid first high 2 cycles after first handshake.
- Hold out_ready=0 -> after 2 entries buffered, imem_req_valid=0; raise out_ready -> fetching resumes with no lost or duplicated PC.
- Redirect to 0x80001003 while in WAIT -> in-flight response dropped; FIFO flushed; next req addr 0x80001000; first out_pc=0x80001000.
- Redirect while req pending and imem_req_ready=0 for 3 cycles -> old address held until accepted; its response dropped; next req at the redirect target.
- imem_rsp_err=1 on fetch of 0x80000008 -> entry emitted with out_err=1; the next fetch at 0x8000000C proceeds normally.
- Assert rst mid-WAIT with FIFO non-empty -> outputs immediately 0; after release, fetch restarts at RESET_PC with no stale entries emitted.

Source files
------------

// File: rtl/ysyx_23060096_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN             : PC / instruction width
//   RESET_PC_DEFAULT : first fetch address after reset
//   ifu_state_e      : fetch FSM encoding (REQ = may issue, WAIT = one request outstanding)
//   fetch_entry_t    : instruction buffer entry {pc, inst, err}
package ysyx_23060096_ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            err;
  } fetch_entry_t;

  // Force a target address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060096_ifu_fifo.sv
// Synchronous instruction buffer with flush.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : discard all entries (wins over push and pop)
//   push, push_data : write one entry
//   pop        : remove the head entry
//   count      : number of valid entries
//   empty      : no valid entries
//   head       : oldest entry, read straight from the storage registers
// The caller guarantees no push while full; a push in that case is ignored.
module ysyx_23060096_ifu_fifo
  import ysyx_23060096_ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (cnt != CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit.
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr: word fetch request channel
//   imem_rsp_valid/data/err  : in-order response channel (valid only)
//   redirect_valid/pc        : restart fetch at a new address, flushing everything
//   out_valid/ready          : instruction handoff to decode
//   out_inst/pc/err          : head entry (zero when out_valid is low)
//   dbg_state                : current fetch FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// raised valid and its payload stay stable until that transfer happens.
module ysyx_23060096_ifu
  import ysyx_23060096_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  output ifu_state_e      dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;   // address of the raised / outstanding request
  logic            pending_q, pending_d; // request raised but not yet accepted
  logic            drop_q, drop_d;       // discard the response of the current request
  logic            started_q;            // keeps the request low until the first edge after reset

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            credit;
  logic            rsp_take;
  logic            push;
  logic            pop;

  // Buffered entries plus the outstanding request must fit in the FIFO.
  assign credit = (fifo_count + CW'(state_q == ST_WAIT)) < CW'(FIFO_DEPTH);

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    drop_d         = drop_q;
    pending_d      = 1'b0;
    rsp_take       = 1'b0;
    imem_req_valid = 1'b0;
    // A pending request keeps its original address even across a redirect.
    imem_req_addr  = pending_q ? req_pc_q : fetch_pc_q;

    case (state_q)
      ST_REQ: begin
        imem_req_valid = started_q && credit;
        if (imem_req_valid) begin
          req_pc_d = imem_req_addr;
          if (imem_req_ready) begin
            state_d = ST_WAIT;
            // drop_q here means a redirect already replaced fetch_pc.
            if (!drop_q) fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_take = !drop_q;
          drop_d   = 1'b0;
          state_d  = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      // Any request whose response is still to come must be discarded.
      if ((state_q == ST_WAIT && !imem_rsp_valid) || imem_req_valid) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
    end
  end

  assign push_entry = '{pc: req_pc_q, inst: imem_rsp_data, err: imem_rsp_err};
  assign push       = rsp_take && !redirect_valid;
  assign pop        = !fifo_empty && out_ready && !redirect_valid;

  ysyx_23060096_ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = out_valid ? fifo_head.pc   : '0;
  assign out_inst  = out_valid ? fifo_head.inst : '0;
  assign out_err   = out_valid ? fifo_head.err  : 1'b0;
  assign dbg_state = state_q;

  // Memory may only answer a request that is outstanding.
  rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (state_q == ST_WAIT));

endmodule
